display_scanner: RTL and testbench
==================================

// Module: display_scanner
// PURPOSE
//   Time-multiplexes six BCD clock digits (HH:MM:SS) onto one shared seven-segment decoder.
//   Each digit gets a fixed time slot. The block drives the 4-bit digit value into the
//   decoder's num_in and a one-hot digit-select to the display commons.
//   Each slot starts with a blanking interval to suppress ghosting between digits.
//   It also supports per-digit blinking (time-set mode) and tens-of-hours leading-zero blanking.
// PARAMETERS
//   SLOT_CYCLES   1000  clk cycles per digit slot; legal range 2..65535
//   BLANK_CYCLES  50    blanked cycles at the start of each slot; legal range 0..SLOT_CYCLES-1
// PORTS
//   clk         in   1   system clock
//   rst_n       in   1   synchronous reset, active-low
//   bcd_in      in   24  six BCD digits, with digit i at [4i+3:4i]
//                        d0 = seconds units, d1 = seconds tens, d2 = minutes units,
//                        d3 = minutes tens, d4 = hours units, d5 = hours tens
//   blink_mask  in   6   bit i set: digit i takes part in blinking
//   blink_on    in   1   blink phase; 1 = masked digits hidden
//   lz_en       in   1   1 = show d5 as blank when it equals 0
//   num_out     out  4   digit value to the decoder; 4'hF = blank (decoder lights no segments)
//   dig_sel     out  6   one-hot digit enable, active-high, bit i = digit i
// BEHAVIOUR
//   - One clock domain. All outputs are registered. There are no combinational paths from inputs to outputs.
//   - Internal state:
//       slot counter cnt, 0..SLOT_CYCLES-1
//       digit index idx, 0..5
//       snapshot register snap[3:0]
//       phase: BLANK when cnt < BLANK_CYCLES, otherwise ON
//   - Reset, while rst_n is sampled low at a clk edge:
//       cnt=0, idx=0, num_out=4'hF, dig_sel=6'b0
//       The snapshot is cleared.
//       Reset overrides all other activity, including mid-slot.
//   - Slot timing: "cycle k" is the k-th clk cycle of the current slot, with k = cnt.
//       In the first cycle after reset release, k=0 and idx=0.
//       When cnt=SLOT_CYCLES-1: cnt wraps to 0 and idx advances (5 wraps to 0).
//       Otherwise cnt increments by 1.
//       One full scan takes 6*SLOT_CYCLES cycles.
//   - Snapshot: on the edge that enters k=0, snap loads bcd_in[4*idx_next+3 : 4*idx_next].
//       Changes to bcd_in within a slot are not visible until the next slot.
//   - Phase BLANK (k < BLANK_CYCLES): dig_sel=0 and num_out=4'hF.
//   - Phase ON (k >= BLANK_CYCLES): dig_sel = 1<<idx.
//       num_out = 4'hF if (blink_mask[idx] && blink_on) or (idx==5 && lz_en && snap==0).
//       Otherwise num_out = snap.
//   - blink_on, blink_mask and lz_en are sampled every cycle. They may change mid-slot and
//     take effect on the next cycle.
//   - Non-BCD snapshot values (A..F) pass through unchanged. The decoder blanks them.
//   - BLANK_CYCLES=0: dig_sel is never all-zero after reset release.
//   - Exactly one dig_sel bit is ever high, or none. No two digits are ever enabled in the same cycle.
//   - Output timing: outputs are registered from the next-state values, so they describe
//     cycle k in the same cycle that cnt=k.
//       First lit cycle after reset release: k=BLANK_CYCLES of slot 0.
// TESTING  (bench uses SLOT_CYCLES=8, BLANK_CYCLES=2)
//   1. Reset: hold rst_n=0 for 3 cycles with bcd_in=24'h123456.
//      -> dig_sel=0 and num_out=F throughout.
//      Release -> cycles 0-1: dig_sel=0, num_out=F.
//      Cycle 2: dig_sel=6'b000001, num_out=6.
//   2. Full scan: bcd_in=24'h123456, all controls 0.
//      -> Lit values are 6,5,4,3,2,1 on dig_sel 000001, 000010, ..., 100000 in turn.
//      -> The pattern repeats at digit 0 after 48 cycles.
//      -> dig_sel is never multi-hot.
//   3. Mid-slot change: bcd_in goes 24'h000005 -> 24'h000009 at slot-0 cycle 4.
//      -> num_out stays 5 until the slot ends.
//      -> The next digit-0 slot shows 9.
//   4. Blink: blink_mask=6'b000011 with blink_on=1.
//      -> Digits 0-1 give num_out=F while dig_sel is still asserted.
//      -> Digits 2-5 are normal.
//      Set blink_on=0 mid-slot -> the real value appears on the next cycle.
//   5. Leading zero: bcd_in=24'h091530.
//      lz_en=1 -> digit-5 slot gives num_out=F.
//      lz_en=0 -> digit-5 slot gives num_out=0.
//      bcd_in=24'h191530 with lz_en=1 -> digit-5 slot gives num_out=1.
//   6. Reset mid-operation: assert rst_n=0 during digit 3 at cycle 5.
//      -> The next cycle gives dig_sel=0 and num_out=F.
//      After release, the scan restarts at digit 0, cycle 0.

Source files
------------

// File: rtl/display_scanner.sv
// display_scanner: time-multiplexes six BCD clock digits (HH:MM:SS) onto one
// shared seven-segment decoder. Each digit owns a fixed slot that opens with a
// blanking interval, and the block supports per-digit blinking and
// leading-zero blanking of the tens-of-hours digit.
module display_scanner #(
    parameter int SLOT_CYCLES  = 1000,
    parameter int BLANK_CYCLES = 50
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] bcd_in,
    input  logic [5:0]  blink_mask,
    input  logic        blink_on,
    input  logic        lz_en,
    output logic [3:0]  num_out,
    output logic [5:0]  dig_sel
);

    localparam int CW = (SLOT_CYCLES > 2) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(SLOT_CYCLES - 1);
    localparam logic [3:0] BLANK_CODE = 4'hF;

    // Slot counter, digit index, per-slot digit snapshot and registered outputs.
    // r_started is low only between reset and the first running edge, so that
    // edge is treated as the one entering cycle 0 of slot 0 and loads the
    // slot-0 snapshot.
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic [3:0]    r_snap;
    logic          r_started;
    logic [3:0]    r_num;
    logic [5:0]    r_dig;

    logic [CW-1:0] w_cnt_nxt;
    logic [2:0]    w_idx_nxt;
    logic          w_load;
    logic [3:0]    w_sel_digit;
    logic [3:0]    w_snap_nxt;
    logic [31:0]   w_cnt_ext;
    logic          w_blank;
    logic          w_hide;
    logic [3:0]    w_num_nxt;
    logic [5:0]    w_dig_nxt;

    // Next slot position: hold at slot 0 / cycle 0 on the first running edge,
    // otherwise count through the slot and advance the digit on wrap.
    always_comb begin
        w_cnt_nxt = r_cnt + CW'(1);
        w_idx_nxt = r_idx;
        w_load    = 1'b0;
        if (!r_started) begin
            w_cnt_nxt = '0;
            w_idx_nxt = 3'd0;
            w_load    = 1'b1;
        end else if (r_cnt == LAST_CNT) begin
            w_cnt_nxt = '0;
            w_idx_nxt = (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
            w_load    = 1'b1;
        end
    end

    // Pick the digit the next slot will display; only used on slot entry.
    always_comb begin
        w_sel_digit = bcd_in[3:0];
        case (w_idx_nxt)
            3'd0:    w_sel_digit = bcd_in[3:0];
            3'd1:    w_sel_digit = bcd_in[7:4];
            3'd2:    w_sel_digit = bcd_in[11:8];
            3'd3:    w_sel_digit = bcd_in[15:12];
            3'd4:    w_sel_digit = bcd_in[19:16];
            3'd5:    w_sel_digit = bcd_in[23:20];
            default: w_sel_digit = bcd_in[3:0];
        endcase
    end

    // Output values for the cycle being entered. The blanking test is written
    // as cnt+1 <= BLANK so it stays meaningful when BLANK_CYCLES is zero.
    always_comb begin
        w_snap_nxt = w_load ? w_sel_digit : r_snap;
        w_cnt_ext  = 32'(w_cnt_nxt);
        w_blank    = (w_cnt_ext + 32'd1) <= 32'(BLANK_CYCLES);
        w_hide     = (blink_mask[w_idx_nxt] && blink_on) ||
                     ((w_idx_nxt == 3'd5) && lz_en && (w_snap_nxt == 4'd0));
        w_dig_nxt  = 6'b0;
        w_num_nxt  = BLANK_CODE;
        if (!w_blank) begin
            w_dig_nxt = 6'b000001 << w_idx_nxt;
            w_num_nxt = w_hide ? BLANK_CODE : w_snap_nxt;
        end
    end

    // State and output registers; reset wins over everything, mid-slot too.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_idx     <= 3'd0;
            r_snap    <= 4'd0;
            r_started <= 1'b0;
            r_num     <= BLANK_CODE;
            r_dig     <= 6'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_idx     <= w_idx_nxt;
            r_snap    <= w_snap_nxt;
            r_started <= 1'b1;
            r_num     <= w_num_nxt;
            r_dig     <= w_dig_nxt;
        end
    end

    assign num_out = r_num;
    assign dig_sel = r_dig;

endmodule

// File: tb/tb_display_scanner.sv
// Bench for display_scanner with SLOT_CYCLES=8, BLANK_CYCLES=2. Driver tasks
// push the hand-derived output for each upcoming cycle, tagged with the cycle
// number it applies to; a monitor on the falling edge pops and compares.
module tb_display_scanner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] bcd_in;
    logic [5:0]  blink_mask;
    logic        blink_on;
    logic        lz_en;
    logic [3:0]  num_out;
    logic [5:0]  dig_sel;

    logic [31:0] cyc = 32'd0;
    logic [41:0] exp_q[$];
    logic [41:0] e;
    int          checks = 0;
    int          errors = 0;

    display_scanner #(.SLOT_CYCLES(8), .BLANK_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .blink_mask(blink_mask),
        .blink_on(blink_on), .lz_en(lz_en), .num_out(num_out), .dig_sel(dig_sel)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    // Expect (d, n) on the outputs after the next rising edge, then advance.
    task automatic tick(input logic [5:0] d, input logic [3:0] n);
        exp_q.push_back({cyc + 32'd1, d, n});
        @(posedge clk);
        #1;
    endtask

    // One whole slot for digit `dg`: two blank cycles then six lit cycles.
    task automatic slot(input int dg, input logic [3:0] lit);
        for (int k = 0; k < 8; k++) begin
            if (k < 2) tick(6'b0, 4'hF);
            else       tick(6'b000001 << dg, lit);
        end
    endtask

    // Partial slot: cycles k0..k1 inclusive of digit dg.
    task automatic part(input int dg, input int k0, input int k1, input logic [3:0] lit);
        for (int k = k0; k <= k1; k++) begin
            if (k < 2) tick(6'b0, 4'hF);
            else       tick(6'b000001 << dg, lit);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0][41:10] < cyc) begin
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL stale_expect cyc=%0d entry for cycle %0d never compared", cyc, e[41:10]);
        end
        if (exp_q.size() > 0 && exp_q[0][41:10] == cyc) begin
            e = exp_q.pop_front();
            checks++;
            if (dig_sel !== e[9:4] || num_out !== e[3:0]) begin
                errors++;
                $display("FAIL outputs cyc=%0d got dig_sel=%b num_out=%h expected dig_sel=%b num_out=%h",
                         cyc, dig_sel, num_out, e[9:4], e[3:0]);
            end
            checks++;
            if ($countones(dig_sel) > 1) begin
                errors++;
                $display("FAIL onehot cyc=%0d got dig_sel=%b expected at most one bit", cyc, dig_sel);
            end
        end
    end

    initial begin
        rst_n = 1'b0; bcd_in = 24'h123456;
        blink_mask = 6'b0; blink_on = 1'b0; lz_en = 1'b0;

        // 1. reset held three cycles
        repeat (3) tick(6'b0, 4'hF);
        rst_n = 1'b1;

        // 2. full scan then repeat at digit 0
        slot(0, 4'h6); slot(1, 4'h5); slot(2, 4'h4);
        slot(3, 4'h3); slot(4, 4'h2); slot(5, 4'h1);
        slot(0, 4'h6);

        // 3. mid-slot bcd change in slot 0
        bcd_in = 24'h000005;
        for (int d = 1; d < 6; d++) slot(d, 4'h0);
        part(0, 0, 3, 4'h5);
        bcd_in = 24'h000009;
        part(0, 4, 7, 4'h5);
        for (int d = 1; d < 6; d++) slot(d, 4'h0);
        slot(0, 4'h9);

        // 4. blink digits 0-1, release blink mid-slot
        bcd_in = 24'h123456; blink_mask = 6'b000011; blink_on = 1'b1;
        slot(1, 4'hF); slot(2, 4'h4); slot(3, 4'h3); slot(4, 4'h2); slot(5, 4'h1);
        part(0, 0, 3, 4'hF);
        blink_on = 1'b0;
        part(0, 4, 7, 4'h6);
        blink_mask = 6'b0;

        // 5. leading-zero blanking of tens of hours
        bcd_in = 24'h091530; lz_en = 1'b1;
        slot(1, 4'h3); slot(2, 4'h5); slot(3, 4'h1); slot(4, 4'h9); slot(5, 4'hF);
        slot(0, 4'h0);
        lz_en = 1'b0;
        slot(1, 4'h3); slot(2, 4'h5); slot(3, 4'h1); slot(4, 4'h9); slot(5, 4'h0);
        slot(0, 4'h0);
        bcd_in = 24'h191530; lz_en = 1'b1;
        slot(1, 4'h3); slot(2, 4'h5); slot(3, 4'h1); slot(4, 4'h9); slot(5, 4'h1);
        slot(0, 4'h0);

        // 6. reset during digit 3 cycle 5, then restart from digit 0
        slot(1, 4'h3); slot(2, 4'h5);
        part(3, 0, 4, 4'h1);
        rst_n = 1'b0;
        repeat (2) tick(6'b0, 4'hF);
        rst_n = 1'b1;
        slot(0, 4'h0); slot(1, 4'h3);

        repeat (3) @(posedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain got %0d pending expectations expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
